// File: rtl/store_pkg.sv
// Shared types and helpers for the sub-word store path.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    MRG,
    WR
  } state_e;

  typedef struct packed {
    size_e             size;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Bit lane (0 = bits [7:0]) holding a given byte address within a word.
  function automatic logic [1:0] lane_index(input logic [1:0] addr, input bit big_endian);
    return big_endian ? 2'(2'd3 - addr) : addr;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte/halfword insertion of store data into an old memory word.
module store_lane_merge
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] merged_c
);

  logic [1:0] byte_addr;

  // Walk the four bit lanes; the lane/address map is its own inverse.
  always_comb begin
    merged_c  = old_word;
    byte_addr = 2'b00;
    for (int k = 0; k < 4; k++) begin
      byte_addr = lane_index(2'(k), BIG_ENDIAN);
      case (size)
        SZ_BYTE: if (byte_addr == addr_lo) merged_c[8*k +: 8] = wdata[7:0];
        SZ_HALF: if (byte_addr[1] == addr_lo[1])
                   merged_c[8*k +: 8] = (byte_addr[0] ^ BIG_ENDIAN) ? wdata[15:8] : wdata[7:0];
        SZ_WORD: merged_c[8*k +: 8] = wdata[8*k +: 8];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// MIPS sb/sh/sw executor for word-only data memory; sub-word stores use read-modify-write.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic [SIZE_W-1:0] Size,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [DATA_W-1:0] MemRData,
  output logic              MemWrEn,
  output logic [DATA_W-1:0] MemWData
);

  state_e            state;
  req_t              req_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] merged_c;
  size_e             req_size;
  logic              unused_addr_hi;

  assign req_size       = size_e'(Size);
  assign unused_addr_hi = ^Addr[DATA_W-1:ADDR_W+2];

  store_lane_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word (old_q),
    .wdata    (req_q.wdata),
    .size     (req_q.size),
    .addr_lo  (req_q.addr_lo),
    .merged_c (merged_c)
  );

  // Sequencer with registered strobes; Done/Err/strobes default low each cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      req_q    <= '0;
      old_q    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      MemAddr  <= '0;
      MemRdEn  <= 1'b0;
      MemWrEn  <= 1'b0;
      MemWData <= '0;
    end else begin
      Done    <= 1'b0;
      Err     <= 1'b0;
      MemRdEn <= 1'b0;
      MemWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            req_q   <= '{size: req_size, addr_lo: Addr[1:0], wdata: WData};
            MemAddr <= Addr[ADDR_W+1:2];
            if (misaligned(req_size, Addr[1:0])) begin
              Err <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state    <= WR;
              Busy     <= 1'b1;
              MemWrEn  <= 1'b1;
              MemWData <= WData;
              Done     <= 1'b1;
            end else begin
              state   <= RD;
              Busy    <= 1'b1;
              MemRdEn <= 1'b1;
            end
          end
        end
        RD:   state <= WAIT;
        WAIT: begin
          old_q <= MemRData;
          state <= MRG;
        end
        MRG: begin
          MemWData <= merged_c;
          MemWrEn  <= 1'b1;
          Done     <= 1'b1;
          state    <= WR;
        end
        WR: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load-path byte/halfword sign extension.
- Executes MIPS sb/sh/sw against the word-only data memory. Full words are written directly; sub-word stores use a read-modify-write sequence.
- Sits between the EX/MEM stage and data memory. Asserts busy to stall the pipeline until the merged word is committed.

Parameters:
- ADDR_W, 10, word-address width of data memory (memory depth = 2^ADDR_W words).
- BIG_ENDIAN, 0, 0 = byte 0 in bits [7:0]; 1 = byte 0 in bits [31:24].

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  store request, sampled in IDLE only.
- Size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- Addr  in  32  byte address.
- WData  in  32  register value; the store data is taken from its low bits.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse in the cycle the memory write is issued.
- Err  out  1  one-cycle pulse on a misaligned or reserved-size request.
- MemAddr  out  ADDR_W  word address, equal to the latched Addr[ADDR_W+1:2].
- MemRdEn  out  1  memory read strobe.
- MemRData  in  32  read data, valid exactly one cycle after MemRdEn.
- MemWrEn  out  1  memory write strobe.
- MemWData  out  32  word to be written.

Behaviour:
- Reset (asynchronous, Reset_n = 0):
  - state = IDLE.
  - Busy, Done, Err, MemRdEn, MemWrEn = 0.
  - MemAddr, MemWData = 0.
  - Latched request registers = 0.
- Reset asserted mid-operation: the sequence is abandoned and no write is issued, including when reset asserts in the WR cycle before the edge.
- IDLE, Req = 1: latch Size, Addr, and WData. Then check the request:
  - Size = 11, or (Size = 01 and Addr[0] = 1), or (Size = 10 and Addr[1:0] != 0) -> Err = 1 for the next cycle, stay IDLE, no memory access.
  - Size = 10 and aligned -> WR.
  - Size = 00 or 01 -> RD.
- RD (1 cycle): MemRdEn = 1, Busy = 1 -> WAIT.
- WAIT (1 cycle): sample MemRData into the merge register -> MRG.
- MRG (1 cycle): compute the merged word.
  - Byte store: replace lane Addr[1:0] with WData[7:0].
  - Halfword store: replace lanes {Addr[1],0} and {Addr[1],1} with WData[15:0], little-endian within the half when BIG_ENDIAN = 0.
  - All other lanes are kept from MemRData.
  - Next state: WR.
- WR (1 cycle): MemWrEn = 1, MemWData = merged word (or the full WData for sw), Done = 1 -> IDLE.
- Latency from the Req cycle (cycle 0):
  - sw: WR and Done at cycle 1.
  - sb/sh: RD at cycle 1, WAIT at cycle 2, MRG at cycle 3, WR and Done at cycle 4.
- Req while Busy = 1 is ignored. The producer must hold it; there is no queueing.
- A new Req may be accepted in the IDLE cycle immediately after Done, which gives back-to-back stores.
- MemRdEn and MemWrEn are never asserted in the same cycle.
- MemAddr holds constant from RD through WR.
- All outputs are registered. Done and Err are never high together.

Decomposition:
- Package store_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum IDLE, RD, WAIT, MRG, WR.
  - Function lane_index(addr[1:0], BIG_ENDIAN).
- Sub-module store_lane_merge: combinational. Inputs old word, WData, Size, Addr[1:0]; output merged word. It is unit-tested separately.
- Top level: FSM plus request registers.

Test Plan:
- Aligned sw: Addr = 0x0000_0008, WData = 0xDEAD_BEEF -> cycle 1 MemWrEn = 1, MemAddr = 2, MemWData = 0xDEADBEEF, Done = 1; MemRdEn is never asserted.
- sb lane 1: memory[3] = 0x1122_3344, Addr = 0x0D, WData = 0xFFFF_FFAB -> MemRdEn at cycle 1; MemWData = 0x1122_AB44 at cycle 4; Busy high for cycles 1-4.
- sh upper half: memory[0] = 0xAAAA_BBBB, Addr = 0x2, WData = 0x0000_1234 -> MemWData = 0x1234_BBBB. With BIG_ENDIAN = 1 the same request gives 0xAAAA_1234.
- Misaligned requests:
  - sh at Addr = 0x3 -> Err pulse 1 cycle, no MemRdEn or MemWrEn, Busy stays 0.
  - sw at Addr = 0x6 -> the same response.
- Reset_n pulsed low during MRG -> all outputs 0 immediately and no MemWrEn afterward. A subsequent sb then completes normally.
- Back-to-back: sb then sw with Req held continuously -> second request accepted in the cycle after the first Done; the two writes are 2 cycles apart; a Req pulse that falls only in busy cycles is dropped.
